// File: rtl/pulse_window_counter_if.sv
// Result port of pulse_window_counter: valid/ready handshake plus the
// per-window count, its flags and the alarm strobe.
interface pulse_window_counter_if #(
  parameter int CNT_W = 8
);
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic             res_sat;
  logic             res_overrun;
  logic             alarm;

  modport master (
    output res_valid, res_count, res_sat, res_overrun, alarm,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_count, res_sat, res_overrun, alarm,
    output res_ready
  );
endinterface

// File: rtl/pulse_window_counter.sv
// Counts single-cycle event pulses over back-to-back programmable windows and
// presents each window's count on a valid/ready result port.
module pulse_window_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   pulse_in,
  input  logic [WIN_W-1:0]       win_len,
  input  logic [CNT_W-1:0]       threshold,
  pulse_window_counter_if.master res
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state, state_nxt;
  logic [WIN_W-1:0] timer, win_q, win_eff;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             sat_q, blocked, last, load, xfer;

  // cnt_inc already includes this cycle's pulse, so it is also the value loaded
  // into the result on a window's last cycle.
  always_comb begin
    win_eff = (win_len == '0) ? WIN_W'(1) : win_len;
    blocked = pulse_in && (&cnt);
    cnt_inc = blocked ? cnt : cnt + CNT_W'(pulse_in);
    last    = (timer == win_q - WIN_W'(1));
    xfer    = res.res_valid && res.res_ready;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_nxt = COUNT;
      end
      COUNT: begin
        if (!en)       state_nxt = IDLE;
        else if (last) load = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Window length is resampled at every window boundary so windows abut.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      win_q <= '0;
      cnt   <= '0;
      sat_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            win_q <= win_eff;
            timer <= '0;
            cnt   <= '0;
            sat_q <= 1'b0;
          end
        end
        COUNT: begin
          if (!en || last) begin
            timer <= '0;
            cnt   <= '0;
            sat_q <= 1'b0;
            if (en) win_q <= win_eff;
          end else begin
            timer <= timer + WIN_W'(1);
            cnt   <= cnt_inc;
            sat_q <= sat_q | blocked;
          end
        end
        default: begin
          timer <= '0;
          cnt   <= '0;
          sat_q <= 1'b0;
        end
      endcase
    end
  end

  // A load always wins over a transfer; overrun marks a result that was never taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res.res_valid   <= 1'b0;
      res.res_count   <= '0;
      res.res_sat     <= 1'b0;
      res.res_overrun <= 1'b0;
      res.alarm       <= 1'b0;
    end else begin
      res.alarm <= load && (threshold != '0) && (cnt_inc >= threshold);
      if (load) begin
        res.res_valid   <= 1'b1;
        res.res_count   <= cnt_inc;
        res.res_sat     <= sat_q | blocked;
        res.res_overrun <= res.res_valid && !res.res_ready;
      end else if (xfer) begin
        res.res_valid <= 1'b0;
      end
    end
  end

endmodule
